// File: rtl/xtea_dec_stream_if.sv
// 32-bit valid/ready stream adapter around the 128-bit XTEA decryptor core.
// Collects four words into a block, runs the core, then drains four result words.
module xtea_dec_stream_if #(
   parameter int WORD_SIZE = 128,
   parameter int LANE_W    = 32,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [WORD_SIZE-1:0] key_in,
   input  logic                 key_load,
   input  logic [LANE_W-1:0]    s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic [WORD_SIZE-1:0] dec_data_in,
   output logic [WORD_SIZE-1:0] dec_key,
   output logic                 dec_start,
   input  logic                 dec_ready,
   input  logic [WORD_SIZE-1:0] dec_data_out,
   output logic [LANE_W-1:0]    m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 busy,
   output logic                 err_timeout
);

   typedef enum logic [1:0] {S_COLLECT, S_START, S_WAIT, S_DRAIN} state_t;

   localparam logic [9:0] TMO_LIMIT = 10'(TIMEOUT);

   state_t               state_q, state_d;
   logic [1:0]           cnt_q, cnt_d;
   logic [9:0]           tmo_q, tmo_d;
   logic [WORD_SIZE-1:0] in_q, in_d;
   logic [WORD_SIZE-1:0] out_q, out_d;
   logic [WORD_SIZE-1:0] key_q, key_d;
   logic [LANE_W-1:0]    m_data_q, m_data_d;
   logic                 s_ready_q, s_ready_d;
   logic                 dec_start_q, dec_start_d;
   logic                 m_valid_q, m_valid_d;
   logic                 busy_q, busy_d;
   logic                 err_q, err_d;

   // Word number cnt maps to lane (3 - cnt), so the first word is the top lane.
   function automatic logic [LANE_W-1:0] lane_for_count(input logic [WORD_SIZE-1:0] blk,
                                                        input logic [1:0] cnt);
      return blk[(3 - int'(cnt))*LANE_W +: LANE_W];
   endfunction

   function automatic logic [WORD_SIZE-1:0] put_lane(input logic [WORD_SIZE-1:0] blk,
                                                     input logic [1:0] cnt,
                                                     input logic [LANE_W-1:0] word);
      logic [WORD_SIZE-1:0] r;
      r = blk;
      r[(3 - int'(cnt))*LANE_W +: LANE_W] = word;
      return r;
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tmo_d    = tmo_q;
      in_d     = in_q;
      out_d    = out_q;
      key_d    = key_q;
      err_d    = err_q;
      m_data_d = m_data_q;

      case (state_q)
         S_COLLECT: begin
            if (s_valid && s_ready_q) begin
               in_d  = put_lane(in_q, cnt_q, s_data);
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = S_START;
            end
         end
         S_START: begin
            tmo_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            tmo_d = tmo_q + 10'd1;
            // A result arriving on the timeout cycle still wins.
            if (dec_ready) begin
               out_d   = dec_data_out;
               cnt_d   = 2'd0;
               state_d = S_DRAIN;
            end else if (tmo_q + 10'd1 == TMO_LIMIT) begin
               err_d   = 1'b1;
               cnt_d   = 2'd0;
               state_d = S_COLLECT;
            end
         end
         S_DRAIN: begin
            if (m_valid_q && m_ready) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = S_COLLECT;
            end
         end
         default: state_d = S_COLLECT;
      endcase

      // The key must not move while the core is working on a block.
      if (key_load && (state_q == S_COLLECT || state_q == S_DRAIN)) key_d = key_in;

      if (state_d == S_DRAIN) m_data_d = lane_for_count(out_d, cnt_d);

      s_ready_d   = (state_d == S_COLLECT);
      dec_start_d = (state_d == S_START);
      m_valid_d   = (state_d == S_DRAIN);
      busy_d      = !(state_d == S_COLLECT && cnt_d == 2'd0);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_COLLECT;
         cnt_q       <= '0;
         tmo_q       <= '0;
         in_q        <= '0;
         out_q       <= '0;
         key_q       <= '0;
         m_data_q    <= '0;
         s_ready_q   <= 1'b0;
         dec_start_q <= 1'b0;
         m_valid_q   <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         in_q        <= in_d;
         out_q       <= out_d;
         key_q       <= key_d;
         m_data_q    <= m_data_d;
         s_ready_q   <= s_ready_d;
         dec_start_q <= dec_start_d;
         m_valid_q   <= m_valid_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign s_ready     = s_ready_q;
   assign dec_data_in = in_q;
   assign dec_key     = key_q;
   assign dec_start   = dec_start_q;
   assign m_data      = m_data_q;
   assign m_valid     = m_valid_q;
   assign busy        = busy_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_xtea_dec_stream_if.sv
// Bench for xtea_dec_stream_if: stub core (result = block ^ key after a set latency),
// table vectors, hand-written corner sequences and randomized blocks against a block ^ key model.
module tb_xtea_dec_stream_if;

   localparam int TMO = 255;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [127:0] key_in = '0;
   logic         key_load = 1'b0;
   logic [31:0]  s_data = '0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [127:0] dec_data_in;
   logic [127:0] dec_key;
   logic         dec_start;
   logic         dec_ready = 1'b0;
   logic [127:0] dec_data_out = '0;
   logic [31:0]  m_data;
   logic         m_valid;
   logic         m_ready = 1'b1;
   logic         busy;
   logic         err_timeout;

   always #5 clock = ~clock;

   xtea_dec_stream_if #(.WORD_SIZE(128), .LANE_W(32), .TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset), .key_in(key_in), .key_load(key_load),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .dec_data_in(dec_data_in), .dec_key(dec_key), .dec_start(dec_start),
      .dec_ready(dec_ready), .dec_data_out(dec_data_out),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .busy(busy), .err_timeout(err_timeout)
   );

   int nchecks = 0;
   int nerrs   = 0;
   int cyc     = 0;

   task automatic tally(input bit ok, input string msg);
      nchecks++;
      if (!ok) begin
         nerrs++;
         $display("FAIL %s", msg);
      end
   endtask
   task automatic chk_bit(input string name, input logic a, input logic e);
      tally(a === e, $sformatf("%s: got %b expected %b", name, a, e));
   endtask
   task automatic chk_word(input string name, input logic [31:0] a, input logic [31:0] e);
      tally(a === e, $sformatf("%s: got %h expected %h", name, a, e));
   endtask
   task automatic chk_vec(input string name, input logic [127:0] a, input logic [127:0] e);
      tally(a === e, $sformatf("%s: got %h expected %h", name, a, e));
   endtask
   task automatic chk_int(input string name, input int a, input int e);
      tally(a == e, $sformatf("%s: got %0d expected %0d", name, a, e));
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // m_ready pattern: 0 = always high, 1 = toggling, 2 = random
   int mready_mode = 0;
   always @(posedge clock) begin
      #1;
      case (mready_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = ~m_ready;
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Output monitor: collects transferred words and watches hold / no-overlap rules.
   logic [31:0] got_q[$];
   int          got_cyc[$];
   int          mvalid_cnt = 0;
   bit          hold_prev = 0;
   logic [31:0] data_prev = '0;
   always @(negedge clock) begin
      if (reset) begin
         hold_prev = 0;
      end else begin
         if (hold_prev) begin
            chk_bit("m_valid_held", m_valid, 1'b1);
            chk_word("m_data_held", m_data, data_prev);
         end
         if (m_valid) begin
            mvalid_cnt++;
            chk_bit("s_ready_in_drain", s_ready, 1'b0);
            if (m_ready) begin
               got_q.push_back(m_data);
               got_cyc.push_back(cyc);
            end
         end
         hold_prev = m_valid && !m_ready;
         data_prev = m_data;
      end
   end

   // Stub core. stub_lat > 0: one-cycle dec_ready stub_lat cycles after the start
   // cycle; stub_lat <= 0: never answers.
   int           stub_lat = 10;
   int           req_cnt = 0, ack_cnt = 0;
   bit           pending = 0;
   int           k_s = 0;
   int           start_cyc = 0;
   logic [127:0] sblk = '0, skey = '0;
   logic [127:0] exp_blk = '0, exp_key = '0;
   always @(negedge clock) begin
      dec_ready = 1'b0;
      if (reset) pending = 0;
      if (ack_cnt != req_cnt) begin
         ack_cnt      = req_cnt;
         dec_ready    = 1'b1;
         dec_data_out = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (pending) begin
         k_s++;
         if (k_s == 1) chk_bit("dec_start_one_cycle", dec_start, 1'b0);
         chk_vec("dec_data_in_stable", dec_data_in, sblk);
         chk_vec("dec_key_stable", dec_key, skey);
         if (stub_lat > 0 && k_s == stub_lat) begin
            dec_ready    = 1'b1;
            dec_data_out = sblk ^ skey;
            pending      = 0;
         end else if (stub_lat <= 0 && k_s >= TMO) begin
            pending = 0;
         end
      end
      if (dec_start && !pending) begin
         chk_vec("dec_data_in_at_start", dec_data_in, exp_blk);
         chk_vec("dec_key_at_start", dec_key, exp_key);
         sblk      = dec_data_in;
         skey      = dec_key;
         pending   = 1;
         k_s       = 0;
         start_cyc = cyc;
      end
   end

   logic [127:0] cur_key = '0;

   // All stimulus tasks start and end at posedge + #1.
   task automatic send_word(input logic [31:0] w, input int gap);
      int n;
      s_valid = 1'b0;
      s_data  = $urandom();
      repeat (gap) @(posedge clock);
      if (gap > 0) #1;
      s_data  = w;
      s_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clock);
         if (s_ready) break;
         n++;
         if (n > 2000) begin
            chk_bit("s_ready_wait_expired", s_ready, 1'b1);
            break;
         end
      end
      @(posedge clock);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic load_key(input logic [127:0] k);
      key_in   = k;
      key_load = 1'b1;
      @(posedge clock);
      #1;
      key_load = 1'b0;
      cur_key  = k;
      @(negedge clock);
      chk_vec("dec_key_after_load", dec_key, k);
      @(posedge clock);
      #1;
   endtask

   task automatic run_block(input logic [127:0] wblk, input logic [127:0] eblk, input int mode,
                            input int lat, input int gapmax, input bit timing);
      int n;
      exp_blk     = wblk;
      exp_key     = cur_key;
      stub_lat    = lat;
      mready_mode = mode;
      got_q.delete();
      got_cyc.delete();
      for (int i = 0; i < 4; i++)
         send_word(wblk[(3-i)*32 +: 32], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
      n = 0;
      while (got_q.size() < 4 && n < lat + 400) begin
         @(posedge clock);
         n++;
      end
      chk_int("out_word_count", got_q.size(), 4);
      for (int i = 0; i < 4 && i < got_q.size(); i++)
         chk_word($sformatf("out_word%0d", i), got_q[i], eblk[(3-i)*32 +: 32]);
      if (timing && got_q.size() == 4) begin
         chk_int("first_word_latency", got_cyc[0] - start_cyc, lat + 1);
         for (int i = 1; i < 4; i++)
            chk_int("word_spacing", got_cyc[i] - got_cyc[i-1], 1);
      end
      #1;
      @(negedge clock);
      chk_bit("busy_after_drain", busy, 1'b0);
      chk_bit("m_valid_after_drain", m_valid, 1'b0);
      chk_bit("s_ready_after_drain", s_ready, 1'b1);
      @(posedge clock);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk_bit({tag, "_s_ready"}, s_ready, 1'b0);
      chk_bit({tag, "_dec_start"}, dec_start, 1'b0);
      chk_bit({tag, "_m_valid"}, m_valid, 1'b0);
      chk_word({tag, "_m_data"}, m_data, 32'h0);
      chk_vec({tag, "_dec_data_in"}, dec_data_in, 128'h0);
      chk_vec({tag, "_dec_key"}, dec_key, 128'h0);
      chk_bit({tag, "_busy"}, busy, 1'b0);
      chk_bit({tag, "_err_timeout"}, err_timeout, 1'b0);
   endtask

   typedef struct {
      logic [127:0] key;
      logic [127:0] blk;
      logic [127:0] exp;
      int           mode;
   } vec_t;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         tbl[3];
      logic [127:0] k1, k2, b;
      int           base, n;

      tbl[0] = '{128'h0, 128'h11111111_22222222_33333333_44444444,
                 128'h11111111_22222222_33333333_44444444, 0};
      tbl[1] = '{128'hFFFFFFFF_00000000_FFFFFFFF_00000000, 128'h11111111_22222222_33333333_44444444,
                 128'hEEEEEEEE_22222222_CCCCCCCC_44444444, 1};
      tbl[2] = '{128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h00000000_FFFFFFFF_A5A5A5A5_12345678,
                 128'hFFFFFFFF_00000000_5A5A5A5A_EDCBA987, 2};
      k1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
      k2 = 128'hCAFEBABE_DEADBEEF_0BADF00D_13579BDF;

      // reset state and first s_ready
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk_reset_outputs("reset");
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk_bit("s_ready_first_cycle", s_ready, 1'b0);
      @(negedge clock);
      chk_bit("s_ready_second_cycle", s_ready, 1'b1);
      @(posedge clock);
      #1;

      // table vectors
      for (int i = 0; i < 3; i++) begin
         load_key(tbl[i].key);
         run_block(tbl[i].blk, tbl[i].exp, tbl[i].mode, 100, 0, tbl[i].mode == 0);
      end
      chk_bit("err_after_table", err_timeout, 1'b0);

      // key_load during S_WAIT is ignored
      load_key(k1);
      b = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
      fork
         run_block(b, b ^ k1, 0, 100, 0, 1);
         begin
            n = 0;
            do begin
               @(negedge clock);
               n++;
            end while (!dec_start && n < 200);
            repeat (10) @(posedge clock);
            #1;
            key_in   = k2;
            key_load = 1'b1;
            @(posedge clock);
            #1;
            key_load = 1'b0;
            @(negedge clock);
            chk_vec("dec_key_in_wait", dec_key, k1);
         end
      join
      chk_vec("dec_key_pulse_dropped", dec_key, k1);
      load_key(k2);

      // dec_ready while idle in S_COLLECT
      base = mvalid_cnt;
      req_cnt++;
      repeat (6) @(negedge clock);
      chk_int("stray_ready_no_output", mvalid_cnt, base);
      chk_bit("stray_ready_busy", busy, 1'b0);
      chk_bit("stray_ready_s_ready", s_ready, 1'b1);
      @(posedge clock);
      #1;
      b = 128'h13579BDF_2468ACE0_FEDCBA98_01234567;
      run_block(b, b ^ k2, 2, 30, 2, 0);

      // core never answers
      b = 128'hDEADBEEF_00C0FFEE_BAADF00D_12345678;
      exp_blk     = b;
      exp_key     = cur_key;
      stub_lat    = 0;
      mready_mode = 0;
      base        = mvalid_cnt;
      for (int i = 0; i < 4; i++) send_word(b[(3-i)*32 +: 32], 0);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!dec_start && n < 50);
      chk_bit("timeout_block_started", dec_start, 1'b1);
      chk_bit("busy_in_start", busy, 1'b1);
      for (int k = 1; k <= 257; k++) begin
         @(negedge clock);
         if (k == 254) chk_bit("err_before_timeout", err_timeout, 1'b0);
         if (k == 256) begin
            chk_bit("err_after_timeout", err_timeout, 1'b1);
            chk_bit("s_ready_after_timeout", s_ready, 1'b1);
            chk_bit("busy_after_timeout", busy, 1'b0);
         end
      end
      chk_int("no_output_on_timeout", mvalid_cnt, base);
      @(posedge clock);
      #1;
      b = 128'h89ABCDEF_01234567_76543210_FEDCBA98;
      run_block(b, b ^ cur_key, 0, 20, 0, 1);
      chk_bit("err_sticky", err_timeout, 1'b1);

      // reset after two of four input words
      send_word(32'hAAAAAAAA, 0);
      send_word(32'hBBBBBBBB, 0);
      @(negedge clock);
      chk_bit("busy_mid_collect", busy, 1'b1);
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      chk_reset_outputs("midreset");
      @(posedge clock);
      #1;
      reset   = 1'b0;
      cur_key = '0;
      load_key(k1);
      b = 128'h55555555_66666666_77777777_88888888;
      run_block(b, b ^ k1, 2, 40, 1, 0);

      // dec_ready on the timeout boundary
      b = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
      run_block(b, b ^ k1, 0, TMO, 0, 1);
      chk_bit("err_on_boundary", err_timeout, 1'b0);

      // randomized blocks
      for (int i = 0; i < 15; i++) begin
         if ($urandom_range(0, 2) == 0) load_key({$urandom(), $urandom(), $urandom(), $urandom()});
         b = {$urandom(), $urandom(), $urandom(), $urandom()};
         run_block(b, b ^ cur_key, 2, int'($urandom_range(1, 40)), 3, 0);
      end
      chk_bit("err_after_random", err_timeout, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
      $finish;
   end

endmodule

// File: doc/xtea_dec_stream_if.md
Name: xtea_dec_stream_if

Overview:
- 32-bit valid/ready stream adapter wrapped around the 128-bit XTEA decryptor core (ports data_in, key, start, ready, data_out).
- Upstream side: collects four 32-bit ciphertext words into one 128-bit block, drives it plus the held key into the core and pulses start.
- Downstream side: captures the core result on its one-cycle ready pulse and streams it out as four 32-bit words.
- Includes a sticky timeout flag for a core that never answers.

Parameters:
- WORD_SIZE, 128, core block width; fixed at 128 (four 32-bit lanes).
- LANE_W, 32, stream word width.
- TIMEOUT, 255, maximum cycles waited in S_WAIT for dec_ready before the block is abandoned. Legal range 1..1023 (10-bit counter).

Ports:
- clock, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- key_in, in, 128, key value; bits [127:96] = k0.
- key_load, in, 1, latch key_in into the key register.
- s_data, in, 32, ciphertext word.
- s_valid, in, 1, s_data valid.
- s_ready, out, 1, adapter accepts s_data.
- dec_data_in, out, 128, block to core data_in.
- dec_key, out, 128, key to core key.
- dec_start, out, 1, start pulse to core.
- dec_ready, in, 1, core ready pulse (one cycle).
- dec_data_out, in, 128, core result, valid when dec_ready=1.
- m_data, out, 32, plaintext word.
- m_valid, out, 1, m_data valid.
- m_ready, in, 1, downstream accepts m_data.
- busy, out, 1, high in every state except S_COLLECT with word count 0.
- err_timeout, out, 1, sticky timeout flag.

Behaviour:
- Reset values:
  - Outputs: s_ready=0, dec_start=0, m_valid=0, m_data=0, dec_data_in=0, dec_key=0, busy=0, err_timeout=0.
  - Internal: state=S_COLLECT, word count=0, timeout counter=0.
  - s_ready first rises the cycle after reset deasserts.
  - Reset mid-operation aborts any block, with no partial output.
- Key handling:
  - key_load is honoured in S_COLLECT and S_DRAIN only; ignored in S_START and S_WAIT.
  - dec_key is the key register. It stays stable from S_START until dec_ready.
- Transfers: a transfer occurs when valid and ready are both high on a rising edge.
- S_COLLECT:
  - s_ready=1.
  - Each s transfer writes s_data into lane (3-count) of the input register. Lane 3 is bits [127:96], so the first word lands in [127:96]. count increments.
  - On the 4th transfer, count wraps to 0 and the next state is S_START.
- S_START (exactly 1 cycle):
  - dec_start=1, s_ready=0.
  - dec_data_in is driven from the input register, stable from the S_START cycle until dec_ready.
  - Timeout counter cleared. Next state: S_WAIT.
- S_WAIT:
  - dec_start=0, s_ready=0. Timeout counter increments each cycle.
  - dec_ready=1: capture dec_data_out into the output register the same edge, then go to S_DRAIN.
  - Counter reaches TIMEOUT without dec_ready: set err_timeout (sticky until reset), discard the block, go to S_COLLECT.
  - dec_ready and the timeout in the same cycle: dec_ready wins; no error.
- S_DRAIN:
  - m_valid=1. m_data = output lane (3-count), i.e. [127:96] first.
  - count advances on each m transfer. m_data is held stable while m_ready=0.
  - After the 4th transfer: count wraps to 0, m_valid drops the next cycle, next state is S_COLLECT.
  - s_ready=0 throughout S_DRAIN; there is no overlap of input and output.
- dec_ready outside S_WAIT is ignored.
- Minimum block-to-block spacing is 2 cycles after drain completes. The core's one cycle in its own waiting state after ready is therefore always met before the next dec_start.
- End-to-end latency:
  - 4 input cycles + 1 (S_START) + core latency + 1 (capture) to the first m_valid.
  - Each following output word follows 1 cycle after the previous transfer when m_ready=1.

Test Plan:
- Stub core returns data XOR key after 100 cycles. key_load with key_in=0. Stream 0x11111111, 0x22222222, 0x33333333, 0x44444444 with m_ready=1 -> dec_data_in=0x11111111_22222222_33333333_44444444 on the dec_start cycle; out words 0x11111111..0x44444444 in order, one per cycle; busy returns low after the last.
- Same stream with key=0xFFFFFFFF_00000000_FFFFFFFF_00000000 and m_ready toggling 1/0 -> out 0xEEEEEEEE, 0x22222222, 0xCCCCCCCC, 0x44444444; m_data held while m_ready=0; s_ready=0 throughout drain.
- key_load pulsed with a new value during S_WAIT -> dec_key unchanged until return to S_COLLECT; a pulse in S_COLLECT is taken the next cycle.
- Stub never asserts dec_ready, TIMEOUT=255 -> err_timeout rises 255 cycles after S_START, adapter back in S_COLLECT, m_valid never asserted; the next block then completes normally with err_timeout still 1.
- Reset asserted after 2 of 4 input words -> all outputs return to reset values the next cycle; a fresh 4-word block decodes correctly, with no leftover words in it.
- dec_ready pulsed during S_COLLECT -> ignored; dec_ready coinciding with the timeout boundary -> data captured, err_timeout stays 0.
